// File: rtl/psg_pkg.sv
// Shared types, constants and byte encoders for the PSG bus writer.
package psg_pkg;

  localparam int         LATCH_BIT = 7;
  localparam logic [1:0] NOISE_CH  = 2'd3;

  typedef struct packed {
    logic [1:0] channel;
    logic       vol;
    logic [9:0] value;
  } psg_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER
  } psg_state_e;

  function automatic logic is_tone(input psg_cmd_t cmd);
    return !cmd.vol && (cmd.channel != NOISE_CH);
  endfunction

  // Noise control only uses three bits; bit 3 of the latch byte is forced low.
  function automatic logic [7:0] latch_byte(input psg_cmd_t cmd);
    logic [7:0] b;
    b = {1'b0, cmd.channel, cmd.vol, cmd.value[3:0]};
    if (!cmd.vol && (cmd.channel == NOISE_CH)) b[3] = 1'b0;
    b[LATCH_BIT] = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] data_byte(input psg_cmd_t cmd);
    return {2'b00, cmd.value[9:4]};
  endfunction

endpackage

// File: rtl/psg_cmd_fifo.sv
// Small synchronous command FIFO with first-word-fall-through head output.
module psg_cmd_fifo
  import psg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  psg_cmd_t                     push_data,
  input  logic                         pop,
  output psg_cmd_t                     pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  psg_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign count      = count_reg;
  assign count_next = count_reg + CW'(do_push) - CW'(do_pop);
  // Head is read combinationally so IDLE can pop and encode in the same cycle.
  assign pop_data   = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/psg_bus_writer.sv
// Serialises buffered PSG register writes into strobed byte writes on the
// D/nWE/nCE/READY bus, with READY-qualified recovery and timeout.
module psg_bus_writer
  import psg_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_channel,
  input  logic                        cmd_vol,
  input  logic [9:0]                  cmd_value,
  output logic [7:0]                  D,
  output logic                        nWE,
  output logic                        nCE,
  input  logic                        READY,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
  output logic                        err_timeout,
  input  logic                        err_clr
);

  localparam int            CW       = $clog2(DEPTH+1);
  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES-1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT-1);

  psg_state_e    state_reg, state_next;
  logic [7:0]    d_reg, d_next;
  logic [7:0]    data_reg, data_next;
  logic          pend_reg, pend_next;
  logic [TW-1:0] cnt_reg, cnt_next;
  logic          nwe_reg;
  logic          cmd_ready_reg;
  logic          busy_reg;
  logic          err_reg;
  logic          push;
  logic          pop;
  logic          timeout_hit;

  psg_cmd_t      push_cmd;
  psg_cmd_t      head_cmd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count_cur;
  logic [CW-1:0] fifo_count_next;

  assign push_cmd = '{channel: cmd_channel, vol: cmd_vol, value: cmd_value};
  assign push     = cmd_valid && cmd_ready_reg && !fifo_full;

  psg_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_data  (push_cmd),
    .pop        (pop),
    .pop_data   (head_cmd),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count_cur),
    .count_next (fifo_count_next)
  );

  always_comb begin
    state_next  = state_reg;
    d_next      = d_reg;
    data_next   = data_reg;
    pend_next   = pend_reg;
    cnt_next    = cnt_reg;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          d_next     = latch_byte(head_cmd);
          data_next  = data_byte(head_cmd);
          pend_next  = is_tone(head_cmd);
          state_next = SETUP;
        end
      end
      SETUP:  state_next = STROBE;
      STROBE: begin
        cnt_next   = '0;
        state_next = RECOVER;
      end
      RECOVER: begin
        if ((cnt_reg >= GAP_LAST) && READY) begin
          if (pend_reg) begin
            d_next     = data_reg;
            pend_next  = 1'b0;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end else if (cnt_reg == TO_LAST) begin
          timeout_hit = 1'b1;
          pend_next   = 1'b0;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      d_reg         <= '0;
      data_reg      <= '0;
      pend_reg      <= 1'b0;
      cnt_reg       <= '0;
      nwe_reg       <= 1'b1;
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      d_reg         <= d_next;
      data_reg      <= data_next;
      pend_reg      <= pend_next;
      cnt_reg       <= cnt_next;
      // Strobe register trails the STROBE state by one edge, so the pin is
      // low for exactly one cycle, the first cycle of RECOVER.
      nwe_reg       <= (state_reg != STROBE);
      cmd_ready_reg <= (fifo_count_next != CW'(DEPTH));
      busy_reg      <= (state_next != IDLE) || (fifo_count_next != '0);
      err_reg       <= timeout_hit || (err_reg && !err_clr);
    end
  end

  assign D           = d_reg;
  assign nWE         = nwe_reg;
  assign nCE         = nwe_reg;
  assign cmd_ready   = cmd_ready_reg;
  assign busy        = busy_reg;
  assign fifo_count  = fifo_count_cur;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_psg_bus_writer.sv
// Self-checking bench: vector table, corner sequences and a randomized run
// against a byte-level reference model with a PSG-side READY responder.
module tb_psg_bus_writer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_channel = '0;
  logic       cmd_vol = 1'b0;
  logic [9:0] cmd_value = '0;
  logic [7:0] D;
  logic       nWE;
  logic       nCE;
  logic       READY = 1'b1;
  logic       busy;
  logic [2:0] fifo_count;
  logic       err_timeout;
  logic       err_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int ready_delay = 1;
  bit hold_low = 1'b0;
  int got_q[$];
  int exp_q[$];
  int strobe_cyc_q[$];

  int rdy_cnt = 0;
  bit prev_low = 1'b0;
  int high_run = 100;
  bit seen_strobe = 1'b0;

  psg_bus_writer dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel), .cmd_vol(cmd_vol), .cmd_value(cmd_value),
    .D(D), .nWE(nWE), .nCE(nCE), .READY(READY), .busy(busy),
    .fifo_count(fifo_count), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference encoding straight from the register-write rules.
  function automatic int model_latch(input int ch, input int vol, input int val);
    int lo;
    lo = (vol == 0 && ch == 3) ? (val % 8) : (val % 16);
    return 128 + ch * 32 + vol * 16 + lo;
  endfunction

  function automatic int model_data(input int val);
    return val / 16;
  endfunction

  // PSG side: capture strobed bytes, check strobe shape, answer with READY.
  always @(negedge CLK) begin
    if (!nWE) begin
      check("strobe_single_cycle", prev_low, 0);
      check("strobe_nce", nCE, 0);
      if (seen_strobe) check("strobe_gap_ok", (high_run >= 2) ? 1 : 0, 1);
      got_q.push_back(int'(D));
      strobe_cyc_q.push_back(cyc);
      prev_low    <= 1'b1;
      high_run    <= 0;
      seen_strobe <= 1'b1;
      rdy_cnt     <= ready_delay;
      READY       <= !hold_low && (ready_delay == 0);
    end else begin
      prev_low <= 1'b0;
      high_run <= high_run + 1;
      if (rdy_cnt > 0) begin
        rdy_cnt <= rdy_cnt - 1;
        READY   <= !hold_low && (rdy_cnt == 1);
      end else begin
        READY <= !hold_low;
      end
    end
  end

  task automatic push_cmd(input int ch, input int vol, input int val, input bit keep);
    int n;
    cmd_channel = 2'(ch);
    cmd_vol     = (vol != 0);
    cmd_value   = 10'(val);
    cmd_valid   = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_bound", cmd_ready, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      last_acc = cyc;
      exp_q.push_back(model_latch(ch, vol, val));
      if (vol == 0 && ch != 3) exp_q.push_back(model_data(val));
      if (!keep) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("drain_bound", busy, 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic compare_queues(input string name);
    int m;
    check({name, "_len"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({name, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    strobe_cyc_q.delete();
  endtask

  typedef struct {
    int ch; int vol; int val; int nb; int b0; int b1;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n;
    int s;
    vecs[0] = '{ch: 0, vol: 0, val: 'h2A5, nb: 2, b0: 'h85, b1: 'h2A};
    vecs[1] = '{ch: 2, vol: 1, val: 'h007, nb: 1, b0: 'hD7, b1: 0};
    vecs[2] = '{ch: 3, vol: 0, val: 'h005, nb: 1, b0: 'hE5, b1: 0};
    vecs[3] = '{ch: 2, vol: 0, val: 'h3FF, nb: 2, b0: 'hCF, b1: 'h3F};
    vecs[4] = '{ch: 3, vol: 0, val: 'h3FF, nb: 1, b0: 'hE7, b1: 0};
    vecs[5] = '{ch: 1, vol: 1, val: 'h3F0, nb: 1, b0: 'hB0, b1: 0};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_nwe", nWE, 1);
    check("rst_nce", nCE, 1);
    check("rst_d", D, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_err", err_timeout, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Vector table
    ready_delay = 1;
    for (int v = 0; v < 6; v++) begin
      push_cmd(vecs[v].ch, vecs[v].vol, vecs[v].val, 1'b0);
      wait_idle();
      check("vec_nbytes", got_q.size(), vecs[v].nb);
      if (got_q.size() > 0) check("vec_latch", got_q[0], vecs[v].b0);
      if (vecs[v].nb == 2 && got_q.size() > 1) check("vec_data", got_q[1], vecs[v].b1);
      if (v == 0 && strobe_cyc_q.size() > 0)
        check("first_strobe_latency", strobe_cyc_q[0] - last_acc, 3);
      got_q.delete();
      exp_q.delete();
      strobe_cyc_q.delete();
    end

    // Back-to-back pushes with a slow PSG fill the FIFO
    ready_delay = 6;
    push_cmd(0, 0, 'h123, 1'b1);
    push_cmd(1, 1, 'h00A, 1'b1);
    push_cmd(3, 0, 'h006, 1'b1);
    push_cmd(2, 0, 'h3C1, 1'b1);
    push_cmd(0, 1, 'h00F, 1'b0);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_count", fifo_count, 4);
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("after_pop_ready", cmd_ready, 1);
    check("after_pop_count", fifo_count, 3);
    push_cmd(1, 0, 'h2F0, 1'b0);
    wait_idle();
    compare_queues("b2b");

    // Timeout on the latch byte of a tone write: data byte must be dropped
    ready_delay = 1;
    hold_low = 1'b1;
    push_cmd(1, 0, 'h155, 1'b0);
    void'(exp_q.pop_back());
    n = 0;
    while (strobe_cyc_q.size() == 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("timeout_strobe_seen", strobe_cyc_q.size(), 1);
    s = (strobe_cyc_q.size() > 0) ? strobe_cyc_q[0] : cyc;
    while (cyc < s + 63) @(negedge CLK);
    check("timeout_not_yet", err_timeout, 0);
    @(negedge CLK);
    check("timeout_set", err_timeout, 1);
    hold_low = 1'b0;
    push_cmd(0, 1, 'h003, 1'b0);
    wait_idle();
    compare_queues("timeout");
    check("err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    check("err_cleared", err_timeout, 0);

    // Reset while the first tone write is in STROBE
    push_cmd(0, 0, 'h2A5, 1'b1);
    s = last_acc;
    push_cmd(2, 1, 'h001, 1'b0);
    while (cyc < s + 2) @(negedge CLK);
    check("pre_rst_count", fifo_count, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_nwe", nWE, 1);
    check("midrst_nce", nCE, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_release_ready", cmd_ready, 1);
    repeat (12) @(negedge CLK);
    check("midrst_no_bytes", got_q.size(), 0);
    got_q.delete();
    exp_q.delete();
    strobe_cyc_q.delete();

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      ready_delay = int'($urandom_range(0, 4));
      push_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1023)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_idle();
    compare_queues("random");
    check("final_err", err_timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
